score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter SCANPERIOD, default 1000, meaning clk3 cycles each digit stays enabled.
REQ-002 SHALL have port clk3  input  1  system clock; all logic is on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port score  input  `scorelen  current game score, binary, driven by the score counter.
REQ-005 SHALL have port gameover  input  1  level, high while the game is over.
REQ-006 SHALL have port seg  output  7  active-low segments, bit order g..a (bit6=g, bit0=a).
REQ-007 SHALL have port an  output  4  active-low digit enables, an[0]=units, an[3]=thousands.
REQ-008 SHALL have port hiscore  output  `scorelen  best score since reset, binary.

Function
REQ-009 SHALL convert binary to 4 BCD digits with a sequential double-dabble FSM: states IDLE, SHIFT, DONE.
REQ-010 IDLE: when score != lastval, SHALL capture score into a shadow register and lastval, then go to SHIFT; otherwise stay in IDLE.
REQ-011 SHIFT: SHALL do exactly one add-3/shift step per cycle, `scorelen steps, then go to DONE.
REQ-012 DONE: SHALL copy the result into the display digit register in one cycle, then return to IDLE.
REQ-013 Score change to updated digit register SHALL take exactly `scorelen+2 cycles.
REQ-014 Shadow values >= 10000 SHALL saturate the displayed digits to 9999.
REQ-015 score changes during SHIFT/DONE SHALL be ignored; the next IDLE cycle compares against lastval, so the final value always gets displayed.
REQ-016 Scan counter SHALL count 0..SCANPERIOD-1 and wrap; on wrap the digit index SHALL step 0->1->2->3->0.
REQ-017 an SHALL drive low only the bit equal to the digit index; all other bits high.
REQ-018 seg decode (hex, active-low) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-019 Leading-zero blanking: digits above the highest non-zero digit SHALL output seg=7F; the units digit SHALL always be shown.
REQ-020 On the rising edge of gameover (internal one-cycle edge detect), if score > hiscore, hiscore SHALL load score on that clock.
REQ-021 gameover held high SHALL NOT update hiscore again; a new rising edge is required.
REQ-022 If the rising edge of gameover and a score change occur in the same cycle, the compare SHALL use the sampled score input of that cycle.

Reset
REQ-023 While reset=0: seg=7F, an=F, hiscore=0, digit register=0, lastval=0, scan counter=0, digit index=0, FSM=IDLE, edge-detect register=0.
REQ-024 Reset asserted mid-conversion SHALL abort it immediately; after release the display SHALL show "0" (units only) until score changes.
REQ-025 First clock after release SHALL drive an=E and seg=40.

Structure
REQ-026 `scorelen SHALL come from the shared defines header; the seg decode constants and the FSM state encodings SHALL live in that header.
REQ-027 The BCD converter SHALL be a sub-module named bin2bcd_seq (start/busy/done handshake); scan and hiscore logic SHALL be in score_display.

Verification (bench: `scorelen=14, SCANPERIOD=4)
REQ-028 Release reset, score=0 -> an cycles E,D,B,7 every 4 clocks; seg=40 on E and 7F on the others; hiscore=0.
REQ-029 score 0->1234 -> digits 1,2,3,4 appear exactly 16 cycles later; seg on an=7 is 79 and on an=E is 19.
REQ-030 score=57 then 58 two cycles later -> display briefly shows 57 and settles on 58 at most 32 cycles after the second change; the thousands and hundreds digits are blanked (7F).
REQ-031 score=12000 -> all four digits show 9 (seg=10).
REQ-032 gameover rises with score=300 -> hiscore=300; it rises again with score=200 -> stays 300; it is held high while score changes to 900 -> stays 300.
REQ-033 Assert reset during SHIFT with score=4321 -> outputs take the reset values at once; after release seg=40 on an=E.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared score-display definitions: score width, segment patterns, converter FSM states.
`ifndef SCORE_DISPLAY_PKG_SV
`define SCORE_DISPLAY_PKG_SV

`define SCORELEN 14

package score_display_pkg;

  localparam int unsigned ScoreLen = `SCORELEN;

  // Active-low segment patterns, bit order g..a.
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] Seg0     = 7'h40;
  localparam logic [6:0] Seg1     = 7'h79;
  localparam logic [6:0] Seg2     = 7'h24;
  localparam logic [6:0] Seg3     = 7'h30;
  localparam logic [6:0] Seg4     = 7'h19;
  localparam logic [6:0] Seg5     = 7'h12;
  localparam logic [6:0] Seg6     = 7'h02;
  localparam logic [6:0] Seg7     = 7'h78;
  localparam logic [6:0] Seg8     = 7'h00;
  localparam logic [6:0] Seg9     = 7'h10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    s = SegBlank;
    case (d)
      4'd0:    s = Seg0;
      4'd1:    s = Seg1;
      4'd2:    s = Seg2;
      4'd3:    s = Seg3;
      4'd4:    s = Seg4;
      4'd5:    s = Seg5;
      4'd6:    s = Seg6;
      4'd7:    s = Seg7;
      4'd8:    s = Seg8;
      4'd9:    s = Seg9;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [15:0] dabble(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, saturating at 9999.
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int unsigned Width = ScoreLen
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [Width-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [15:0]      o_bcd
);

  localparam int unsigned CntW = $clog2(Width + 1);

  bcd_state_e       r_state;
  logic [Width-1:0] r_shadow;
  logic [15:0]      r_acc;
  logic             r_sat;
  logic [CntW-1:0]  r_step;
  logic [15:0]      w_adj;

  assign w_adj = dabble(r_acc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_step   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_shadow <= i_bin;
            r_sat    <= (32'(i_bin) >= 32'd10000);
            r_acc    <= '0;
            r_step   <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc    <= {w_adj[14:0], r_shadow[Width-1]};
          r_shadow <= r_shadow << 1;
          r_step   <= r_step + CntW'(1);
          if (r_step == CntW'(Width - 1)) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == DONE);
  assign o_bcd  = r_sat ? 16'h9999 : r_acc;

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display with leading-zero blanking and a high-score latch.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned SCANPERIOD = 1000
) (
  input  logic                 clk3,
  input  logic                 reset,
  input  logic [`SCORELEN-1:0] score,
  input  logic                 gameover,
  output logic [6:0]           seg,
  output logic [3:0]           an,
  output logic [`SCORELEN-1:0] hiscore
);

  localparam int unsigned ScanW = (SCANPERIOD > 1) ? $clog2(SCANPERIOD) : 1;

  logic [`SCORELEN-1:0] r_lastval;
  logic [`SCORELEN-1:0] r_hiscore;
  logic [15:0]          r_digits;
  logic [ScanW-1:0]     r_scan_cnt;
  logic [1:0]           r_digit_idx;
  logic                 r_active;
  logic                 r_gameover_q;

  logic        w_start;
  logic        w_busy;
  logic        w_done;
  logic [15:0] w_bcd;
  logic [3:0]  w_digit;
  logic        w_blank;

  assign w_start = !w_busy && (score != r_lastval);

  bin2bcd_seq #(
    .Width(`SCORELEN)
  ) u_bin2bcd (
    .i_clk  (clk3),
    .i_rst_n(reset),
    .i_start(w_start),
    .i_bin  (score),
    .o_busy (w_busy),
    .o_done (w_done),
    .o_bcd  (w_bcd)
  );

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      r_lastval    <= '0;
      r_hiscore    <= '0;
      r_digits     <= '0;
      r_scan_cnt   <= '0;
      r_digit_idx  <= '0;
      r_active     <= 1'b0;
      r_gameover_q <= 1'b0;
    end else begin
      r_gameover_q <= gameover;
      if (w_start) r_lastval <= score;
      if (w_done) r_digits <= w_bcd;
      if (gameover && !r_gameover_q && (score > r_hiscore)) r_hiscore <= score;
      // The first cycle after reset only enables the display, so digit 0 gets a full period.
      if (!r_active) begin
        r_active <= 1'b1;
      end else if (r_scan_cnt == ScanW'(SCANPERIOD - 1)) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + ScanW'(1);
      end
    end
  end

  always_comb begin
    w_digit = r_digits[3:0];
    w_blank = 1'b0;
    unique case (r_digit_idx)
      2'd0: begin
        w_digit = r_digits[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_digits[7:4];
        w_blank = (r_digits[15:4] == 12'd0);
      end
      2'd2: begin
        w_digit = r_digits[11:8];
        w_blank = (r_digits[15:8] == 8'd0);
      end
      2'd3: begin
        w_digit = r_digits[15:12];
        w_blank = (r_digits[15:12] == 4'd0);
      end
      default: begin
        w_digit = r_digits[3:0];
        w_blank = 1'b0;
      end
    endcase
    seg = SegBlank;
    an  = 4'hF;
    if (r_active) begin
      seg = w_blank ? SegBlank : seg_decode(w_digit);
      an  = ~(4'b0001 << r_digit_idx);
    end
  end

  assign hiscore = r_hiscore;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a queue of expected displayed values.
module tb_score_display;
  import score_display_pkg::*;

  localparam int unsigned W = ScoreLen;

  logic         clk3;
  logic         reset;
  logic [W-1:0] score;
  logic         gameover;
  logic [6:0]   seg;
  logic [3:0]   an;
  logic [W-1:0] hiscore;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  score_display #(
    .SCANPERIOD(4)
  ) dut (
    .clk3    (clk3),
    .reset   (reset),
    .score   (score),
    .gameover(gameover),
    .seg     (seg),
    .an      (an),
    .hiscore (hiscore)
  );

  initial clk3 = 1'b0;
  always #5 clk3 = ~clk3;

  function automatic logic [6:0] ref_seg(input int val, input int k);
    logic [6:0] tab [10];
    int v;
    int p;
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    v = (val >= 10000) ? 9999 : val;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 7'h7F;
    return tab[(v / p) % 10];
  endfunction

  function automatic int an_to_idx(input logic [3:0] a);
    case (a)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the digit currently being scanned against the reference display of val.
  task automatic chk_cur(input string tag, input int val);
    int idx;
    idx = an_to_idx(an);
    chk({tag, "_an_onehot"}, 32'(idx >= 0), 32'd1);
    if (idx >= 0) chk({tag, "_seg"}, 32'(seg), 32'(ref_seg(val, idx)));
  endtask

  // Watch one full scan rotation and compare every digit to the next queued value.
  task automatic scan_check(input string tag);
    int val;
    chk({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      val = exp_q.pop_front();
      for (int c = 0; c < 16; c++) begin
        @(negedge clk3);
        chk_cur(tag, val);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    score    = '0;
    gameover = 1'b0;
    repeat (3) @(negedge clk3);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_hiscore", 32'(hiscore), 32'd0);

    // Release and watch the an rotation, four clocks per digit.
    reset = 1'b1;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] an_tab [4];
      an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
      @(negedge clk3);
      if (c == 0) chk("first_seg", 32'(seg), 32'h40);
      chk("scan_an", 32'(an), 32'(an_tab[c / 4]));
      chk("scan0_seg", 32'(seg), 32'(ref_seg(0, c / 4)));
    end
    chk("hiscore_idle", 32'(hiscore), 32'd0);

    // Conversion latency: old value after 15 clocks, new value after 16.
    score = W'(1234);
    exp_q.push_back(1234);
    repeat (15) @(negedge clk3);
    chk_cur("pre1234", 0);
    @(negedge clk3);
    chk_cur("at1234", 1234);
    scan_check("d1234");

    // Change during conversion: 57 shows first, then 58 settles.
    score = W'(57);
    @(negedge clk3);
    @(negedge clk3);
    score = W'(58);
    repeat (14) @(negedge clk3);
    chk_cur("show57", 57);
    exp_q.push_back(58);
    repeat (18) @(negedge clk3);
    scan_check("d58");

    score = W'(12000);
    exp_q.push_back(12000);
    repeat (20) @(negedge clk3);
    scan_check("sat");

    // High score latch on gameover rising edges only.
    score    = W'(300);
    gameover = 1'b1;
    @(negedge clk3);
    chk("hi300", 32'(hiscore), 32'd300);
    gameover = 1'b0;
    @(negedge clk3);
    score    = W'(200);
    gameover = 1'b1;
    @(negedge clk3);
    chk("hi_lower", 32'(hiscore), 32'd300);
    score = W'(900);
    repeat (3) @(negedge clk3);
    chk("hi_held", 32'(hiscore), 32'd300);
    gameover = 1'b0;
    @(negedge clk3);
    gameover = 1'b1;
    @(negedge clk3);
    chk("hi900", 32'(hiscore), 32'd900);
    gameover = 1'b0;
    repeat (40) @(negedge clk3);

    // Reset in the middle of a conversion.
    score = W'(4321);
    repeat (5) @(negedge clk3);
    reset = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_hi", 32'(hiscore), 32'd0);
    @(negedge clk3);
    reset = 1'b1;
    @(negedge clk3);
    chk("post_rst_an", 32'(an), 32'hE);
    chk("post_rst_seg", 32'(seg), 32'h40);
    exp_q.push_back(4321);
    repeat (20) @(negedge clk3);
    scan_check("d4321");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
